timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_prescaler.sv | 29 ++
 rtl/timer_counter.sv | 58 +++++
 tb/tb_timer_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, prescaler select encodings and tick-mask helper for the timer.
package timer_pkg;
   localparam int CNT_W = 8;
   localparam int DIV_W = 4;
   typedef enum logic [1:0] {
      CKS_DIV2  = 2'b00,
      CKS_DIV4  = 2'b01,
      CKS_DIV8  = 2'b10,
      CKS_DIV16 = 2'b11
   } cks_e;
   // Low divider bits that must all be ones for a tick: 2^(cks+1)-1.
   function automatic logic [DIV_W-1:0] tick_mask(input logic [1:0] cks);
      return (cks == CKS_DIV2) ? 4'b0001 :
             (cks == CKS_DIV4) ? 4'b0011 :
             (cks == CKS_DIV8) ? 4'b0111 : 4'b1111;
   endfunction
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running divider cleared by en, tick on selected all-ones pattern.
// Optional TIMER_DBG_HALT_EN adds dbg_halt, which freezes the divider and masks ticks.
module timer_prescaler
   import timer_pkg::*;
(
   input  logic       pclk,
   input  logic       presetn,
   input  logic       en,
   input  logic [1:0] cks,
`ifdef TIMER_DBG_HALT_EN
   input  logic       dbg_halt,
`endif
   output logic       tick
);
   logic [DIV_W-1:0] div_q, div_d;
   logic             run;
`ifdef TIMER_DBG_HALT_EN
   assign run = en & ~dbg_halt;
`else
   assign run = en;
`endif
   always_comb begin
      div_d = !en ? '0 : run ? div_q + 1'b1 : div_q;
      tick  = run && ((div_q & tick_mask(cks)) == tick_mask(cks));
   end
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) div_q <= '0;
      else          div_q <= div_d;
endmodule

// File: rtl/timer_counter.sv
// timer_counter: 8-bit up/down timer with reload, prescaled ticks and sticky wrap flags.
// Optional TIMER_DBG_HALT_EN adds dbg_halt, which freezes counting and flag setting.
module timer_counter
   import timer_pkg::*;
(
   input  logic             pclk,
   input  logic             presetn,
   input  logic [CNT_W-1:0] tdr,
   input  logic             load,
   input  logic             up_down,
   input  logic             en,
   input  logic [1:0]       cks,
   input  logic             ovf_clr,
   input  logic             udf_clr,
`ifdef TIMER_DBG_HALT_EN
   input  logic             dbg_halt,
`endif
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             udf
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, udf_q, udf_d;
   logic             tick, halt, set_ovf, set_udf;
`ifdef TIMER_DBG_HALT_EN
   assign halt = dbg_halt;
   timer_prescaler u_pre (
      .pclk(pclk), .presetn(presetn), .en(en), .cks(cks), .dbg_halt(dbg_halt), .tick(tick)
   );
`else
   assign halt = 1'b0;
   timer_prescaler u_pre (
      .pclk(pclk), .presetn(presetn), .en(en), .cks(cks), .tick(tick)
   );
`endif
   always_comb begin
      set_ovf = tick && !load && !halt && !up_down && (cnt_q == '1);
      set_udf = tick && !load && !halt && up_down && (cnt_q == '0);
      cnt_d   = halt ? cnt_q :
                load ? tdr :
                tick ? (up_down ? cnt_q - 1'b1 : cnt_q + 1'b1) : cnt_q;
      ovf_d   = set_ovf || (ovf_q && !ovf_clr);
      udf_d   = set_udf || (udf_q && !udf_clr);
   end
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   assign cnt = cnt_q;
   assign ovf = ovf_q;
   assign udf = udf_q;
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed checks of reload, prescaled up/down counting, flags and reset.
module tb_timer_counter;
   logic       pclk = 1'b0;
   logic       presetn, load, up_down, en, ovf_clr, udf_clr, dbg_halt;
   logic [7:0] tdr, cnt;
   logic [1:0] cks;
   logic       ovf, udf;
   int         checks = 0, failures = 0;

   always #5 pclk = ~pclk;

   timer_counter dut (
      .pclk(pclk), .presetn(presetn), .tdr(tdr), .load(load), .up_down(up_down),
      .en(en), .cks(cks), .ovf_clr(ovf_clr), .udf_clr(udf_clr),
`ifdef TIMER_DBG_HALT_EN
      .dbg_halt(dbg_halt),
`endif
      .cnt(cnt), .ovf(ovf), .udf(udf)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn = 1'b0; tdr = '0; load = 1'b0; up_down = 1'b0; en = 1'b0;
      cks = 2'b00; ovf_clr = 1'b0; udf_clr = 1'b0; dbg_halt = 1'b0;
      #3;
      chk("rst_cnt", cnt, 8'h00);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_udf", udf, 1'b0);
      cyc(2);
      presetn = 1'b1;
      // Down count from 5 at divide-by-8: underflow visible 48 cycles after en.
      tdr = 8'h05; load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("load_05", cnt, 8'h05);
      up_down = 1'b1; cks = 2'b10; en = 1'b1;
      cyc(8);
      chk("first_tick_04", cnt, 8'h04);
      cyc(39);
      chk("cyc47_cnt", cnt, 8'h00);
      chk("cyc47_udf", udf, 1'b0);
      cyc(1);
      chk("cyc48_cnt", cnt, 8'hFF);
      chk("cyc48_udf", udf, 1'b1);
      // Clear coincident with a second underflow must lose to the set.
      en = 1'b0; tdr = 8'h00; load = 1'b1; cks = 2'b00;
      cyc(1);
      load = 1'b0; en = 1'b1;
      chk("udf_sticky", udf, 1'b1);
      cyc(1);
      udf_clr = 1'b1;
      cyc(1);
      udf_clr = 1'b0;
      chk("wrap2_cnt", cnt, 8'hFF);
      chk("clr_vs_set", udf, 1'b1);
      cyc(1);
      udf_clr = 1'b1;
      cyc(1);
      udf_clr = 1'b0;
      chk("lone_clr", udf, 1'b0);
      chk("cnt_fe", cnt, 8'hFE);
      en = 1'b0;
      cyc(10);
      chk("en0_freeze", cnt, 8'hFE);
      // Up count from FE at divide-by-2: FF at cycle 4, overflow at cycle 6.
      tdr = 8'hFE; load = 1'b1; up_down = 1'b0;
      cyc(1);
      load = 1'b0;
      cyc(1);
      en = 1'b1;
      cyc(2);
      chk("ovf_c4_cnt", cnt, 8'hFF);
      chk("ovf_c4_flag", ovf, 1'b0);
      cyc(2);
      chk("ovf_c6_cnt", cnt, 8'h00);
      chk("ovf_c6_flag", ovf, 1'b1);
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", ovf, 1'b0);
      // Held load discards every tick and sets no flag.
      load = 1'b1; tdr = 8'h00; up_down = 1'b1;
      cyc(40);
      chk("load_hold_cnt", cnt, 8'h00);
      chk("load_hold_udf", udf, 1'b0);
      load = 1'b0;
      // Async reset mid-count with ovf set.
      en = 1'b0; tdr = 8'hFF; load = 1'b1; up_down = 1'b0;
      cyc(1);
      load = 1'b0; en = 1'b1;
      cyc(2);
      chk("pre_rst_ovf", ovf, 1'b1);
      tdr = 8'h3A; load = 1'b1;
      cyc(1);
      load = 1'b0;
      chk("pre_rst_cnt", cnt, 8'h3A);
      #2 presetn = 1'b0;
      #1;
      chk("async_cnt", cnt, 8'h00);
      chk("async_ovf", ovf, 1'b0);
      en = 1'b0;
      #2 presetn = 1'b1;
      cyc(5);
      chk("post_rst_idle", cnt, 8'h00);
      en = 1'b1;
      cyc(1);
      chk("post_rst_c1", cnt, 8'h00);
      cyc(1);
      chk("post_rst_c2", cnt, 8'h01);
      // Select change mid-run keeps divider progress.
      en = 1'b0;
      cyc(1);
      cks = 2'b01; en = 1'b1;
      cyc(3);
      chk("div4_c3", cnt, 8'h01);
      cyc(1);
      chk("div4_c4", cnt, 8'h02);
      cks = 2'b00;
      cyc(1);
      chk("cks_chg_c5", cnt, 8'h02);
      cyc(1);
      chk("cks_chg_c6", cnt, 8'h03);
`ifdef TIMER_DBG_HALT_EN
      // Halt for 20 cycles delays the divide-by-16 underflow by exactly 20.
      en = 1'b0; tdr = 8'h01; load = 1'b1; up_down = 1'b1; cks = 2'b11;
      cyc(1);
      load = 1'b0; en = 1'b1;
      cyc(10);
      dbg_halt = 1'b1;
      cyc(20);
      chk("halt_cnt", cnt, 8'h01);
      dbg_halt = 1'b0;
      cyc(21);
      chk("halt_c51_udf", udf, 1'b0);
      cyc(1);
      chk("halt_c52_udf", udf, 1'b1);
      chk("halt_c52_cnt", cnt, 8'hFF);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
